// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample prescaler: one-clk tick every CLOCK_SCALE clks while not held in restart.
// Latency: first tick CLOCK_SCALE clks after restart drops.
// Backpressure: none; free-running while enabled.
module uart_rx_tick_gen import uart_pkg::*; #(
  parameter int CLOCK_SCALE = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLOCK_SCALE > 1) ? $clog2(CLOCK_SCALE) : 1;

  logic [CW-1:0] count;

  // Count 0..CLOCK_SCALE-1; restart pins the count at zero so a new frame starts phase-aligned.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count <= '0;
    end else if (count == CW'(CLOCK_SCALE - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = !reset && !restart && (count == CW'(CLOCK_SCALE - 1));

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling and sticky status flags.
// Latency: data_received rises 1 clk after the stop-bit mid-point tick (~9.5 bit times + 2 sync clks).
// Backpressure: none; a byte arriving while data_received=1 is dropped and flagged as overrun.
module uart_rx_core import uart_pkg::*; #(
  parameter int CLOCK_SCALE = 26,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       clear_dr,
  output logic [7:0] rx_data,
  output logic       data_received,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_active
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  rx_state_t      state;
  logic           rx_meta;
  logic           rx_sync;
  logic           tick;
  logic [TW-1:0]  tick_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [7:0]     shift;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  uart_rx_tick_gen #(
    .CLOCK_SCALE(CLOCK_SCALE)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (state == ST_IDLE),
    .tick    (tick)
  );

  // Receive FSM with registered outputs; frame completion overrides a coincident clear_dr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= 8'h00;
      rx_data       <= 8'h00;
      data_received <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      rx_active     <= 1'b0;
    end else begin
      if (clear_dr) begin
        data_received <= 1'b0;
        framing_error <= 1'b0;
        overrun       <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            state     <= ST_START;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            rx_active <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == TW'(OVERSAMPLE / 2 - 1)) begin
              tick_cnt <= '0;
              if (!rx_sync) begin
                state <= ST_DATA;
              end else begin
                state     <= ST_IDLE;
                rx_active <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
              tick_cnt       <= '0;
              shift[bit_cnt] <= rx_sync;
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
              tick_cnt  <= '0;
              rx_active <= 1'b0;
              if (rx_sync) begin
                state <= ST_IDLE;
                if (!data_received || clear_dr) begin
                  rx_data       <= shift;
                  data_received <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                state         <= ST_BREAK;
                framing_error <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_BREAK: begin
          if (rx_sync) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboarded bench for uart_rx_core: directed frames plus randomized traffic.
// Latency: checks data_received timing against the falling edge of the start bit.
// Backpressure: exercises overrun and clear_dr races.
module tb_uart_rx_core;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       clear_dr;
  logic [7:0] rx_data;
  logic       data_received;
  logic       framing_error;
  logic       overrun;
  logic       rx_active;

  uart_rx_core #(
    .CLOCK_SCALE(4),
    .OVERSAMPLE (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .clear_dr      (clear_dr),
    .rx_data       (rx_data),
    .data_received (data_received),
    .framing_error (framing_error),
    .overrun       (overrun),
    .rx_active     (rx_active)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       dr;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the visible receiver state.
  logic [7:0] m_data = 8'h00;
  logic       m_dr = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;

  int lat = 611;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic push_exp(input string nm);
    exp_t e;
    e.name = nm;
    e.data = m_data;
    e.dr   = m_dr;
    e.fe   = m_fe;
    e.ov   = m_ov;
    sb.push_back(e);
  endtask

  // One frame ends: a simultaneous clear applies first, then the frame outcome.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit clr);
    if (clr) begin
      m_dr = 1'b0;
      m_fe = 1'b0;
      m_ov = 1'b0;
    end
    if (stop_ok) begin
      if (!m_dr) begin
        m_data = d;
        m_dr   = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit clr);
    model_frame(d, stop_ok, clr);
    push_exp($sformatf("frame_%02h", d));
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
    if (!stop_ok) begin
      repeat (100) @(negedge clk);
      chk("break_no_retrigger", rx_active, 0);
      rx = 1'b1;
    end
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_false_start(input int low_clks);
    push_exp("false_start");
    rx = 1'b0;
    repeat (low_clks) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS + 32) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_dr = 1'b1;
    @(negedge clk);
    clear_dr = 1'b0;
    m_dr = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  // Monitor: every end of activity (frame done, break, false start, reset) consumes one expectation.
  initial begin
    logic prev_act;
    exp_t e;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_act && !rx_active) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_end_of_activity: got event, expected none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_rx_data"}, rx_data, e.data);
          chk({e.name, "_data_received"}, data_received, e.dr);
          chk({e.name, "_framing_error"}, framing_error, e.fe);
          chk({e.name, "_overrun"}, overrun, e.ov);
        end
      end
      prev_act = rx_active;
    end
  end

  initial begin
    int c0;
    int r;
    logic [7:0] d;

    reset    = 1'b1;
    rx       = 1'b1;
    clear_dr = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_data_received", data_received, 0);
    chk("reset_framing_error", framing_error, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_rx_active", rx_active, 0);
    repeat (20) @(negedge clk);

    // Good frame with latency measurement from the start-bit falling edge.
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 1000 && !data_received; i++) @(negedge clk);
        lat = cyc - c0;
        n_vec++;
        if (lat < 606 || lat > 614) begin
          n_err++;
          $display("FAIL latency_A5: got %0d clk, expected 610 +/- 4", lat);
        end
      end
    join

    // Short low glitch with a byte still pending: nothing changes.
    send_false_start(20);
    pulse_clear();

    // Bad stop bit held low, then a clean frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    pulse_clear();

    // Two back-to-back bytes without clearing, then one clear.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    pulse_clear();
    chk("clear_data_received", data_received, 0);
    chk("clear_framing_error", framing_error, 0);
    chk("clear_overrun", overrun, 0);

    // clear_dr lands on the completion edge of 0x7E while 0x42 is pending.
    send_frame(8'h42, 1'b1, 1'b0);
    c0 = cyc;
    fork
      send_frame(8'h7E, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 2000 && cyc != c0 + lat - 1; i++) @(negedge clk);
        clear_dr = 1'b1;
        @(negedge clk);
        clear_dr = 1'b0;
      end
    join
    pulse_clear();

    // Reset in the middle of bit 4, then a full frame.
    d = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    m_data = 8'h00;
    m_dr   = 1'b0;
    m_fe   = 1'b0;
    m_ov   = 1'b0;
    push_exp("mid_frame_reset");
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_rx_data", rx_data, 8'h00);
    chk("midreset_data_received", data_received, 0);
    chk("midreset_rx_active", rx_active, 0);
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    pulse_clear();

    // Randomized traffic.
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_false_start($urandom_range(2, 28));
      end else begin
        d = 8'($urandom_range(0, 255));
        send_frame(d, $urandom_range(0, 3) != 0, 1'b0);
      end
      if ($urandom_range(0, 1) == 1) pulse_clear();
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLOCK_SCALE, default 26: clk cycles per oversample tick, legal range 1 or more.
REQ-002 Parameter OVERSAMPLE, default 16: ticks per bit, even, legal range 8 or more.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 clear_dr  input  1  single-cycle acknowledge that clears data_received, framing_error and overrun.
REQ-007 rx_data  output  8  last accepted byte.
REQ-008 data_received  output  1  sticky: a byte is waiting.
REQ-009 framing_error  output  1  sticky: a stop bit was sampled low.
REQ-010 overrun  output  1  sticky: a byte completed while data_received=1.
REQ-011 rx_active  output  1  high in every state except IDLE and BREAK.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; every reference to rx below means the synchronized value.
REQ-013 The tick generator SHALL count 0..CLOCK_SCALE-1 and pulse tick for one clk when the count wraps; it counts only outside IDLE and restarts from 0 on the transition into START.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-015 IDLE: when rx=0, go to START and clear the tick-in-bit counter and the bit counter.
REQ-016 START: on tick number OVERSAMPLE/2 (mid-bit), go to DATA if rx=0, otherwise go to IDLE (false start; no flags change).
REQ-017 DATA: every OVERSAMPLE ticks after the start mid-point, shift rx into bit[bitcount], LSB first; after bit 7 go to STOP.
REQ-018 STOP: OVERSAMPLE ticks after the bit-7 sample, sample rx.
REQ-019 If the stop sample is 1 and data_received=0: load rx_data, set data_received on the next clk edge, go to IDLE.
REQ-020 If the stop sample is 1 and data_received=1: leave rx_data unchanged (drop the new byte), set overrun, go to IDLE.
REQ-021 If the stop sample is 0: set framing_error, leave rx_data and data_received unchanged, go to BREAK.
REQ-022 BREAK: stay until rx=1, then go to IDLE, so a held-low line never retriggers a start.
REQ-023 clear_dr SHALL clear data_received, framing_error and overrun on the next edge.
REQ-024 If clear_dr coincides with a stop-bit completion event, the completion SHALL win: the flag is set, rx_data is loaded and overrun is not raised.
REQ-025 Latency: data_received SHALL rise exactly 1 clk after the stop mid-bit tick, which is about 9.5 bit times plus 2 synchronizer clks after the falling edge of rx.
REQ-026 All counters SHALL be sized with $clog2 of their parameter and SHALL never wrap in normal operation.

Reset
REQ-027 On reset: FSM=IDLE, all counters 0, synchronizer=1, rx_data=8'h00, data_received=0, framing_error=0, overrun=0, rx_active=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no flag or data update; reception resumes on the next falling edge after release.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state typedef, the default OVERSAMPLE value and DATA_BITS=8.
REQ-030 One sub-module, uart_rx_tick_gen, SHALL implement the CLOCK_SCALE prescaler with inputs clk, reset and restart and output tick.

Verification (CLOCK_SCALE=4, OVERSAMPLE=16, so 64 clk per bit)
REQ-031 Send frame 0xA5 with a good stop bit -> data_received=1, rx_data=8'hA5, framing_error=0, first asserted 610 clk (+/-4) after the falling edge of rx.
REQ-032 Drive rx low for 20 clk, then high -> returns to IDLE; data_received, framing_error and rx_data unchanged.
REQ-033 Send 0x3C with the stop bit held low, then release rx -> framing_error=1, data_received=0; passes through BREAK; the next frame 0x55 is received correctly.
REQ-034 Send 0x11 then 0x22 with no clear_dr -> rx_data=8'h11, overrun=1; one clear_dr pulse -> all three flags 0.
REQ-035 Pulse clear_dr in the completion cycle of byte 0x7E while a previous byte is pending -> data_received=1, rx_data=8'h7E, overrun=0.
REQ-036 Assert reset in the middle of bit 4 of a frame -> all outputs at reset values; the next full frame 0x81 is received correctly.
